// File: rtl/irq_ctrl.sv
// Machine-mode external interrupt controller: synchronises peripheral level requests,
// latches rising edges as pending and sequences take / handler / WFI sleep for the CSR unit.
module irq_ctrl #(
   parameter int NUM_SRC     = 4,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 16,
   localparam int ID_W       = $clog2(NUM_SRC)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_SRC-1:0] irq_src_i,
   input  logic               mstatus_mie_i,
   input  logic               mie_meie_i,
   input  logic               wfi_i,
   input  logic               mret_i,
   input  logic               pipe_stall_i,
   output logic               interrupt_o,
   output logic [ID_W-1:0]    irq_id_o,
   output logic               sleep_o,
   output logic               in_handler_o,
   output logic [NUM_SRC-1:0] pending_o,
   output logic [CNT_W-1:0]   irq_count_o
);

   typedef enum logic [1:0] {
      ST_RUN,
      ST_SLEEP,
      ST_TAKE,
      ST_HANDLER
   } state_e;

   logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
   logic [NUM_SRC-1:0] synced_d_q;
   logic [NUM_SRC-1:0] rise;
   logic [NUM_SRC-1:0] pending_q;
   logic [NUM_SRC-1:0] clr_mask;
   logic [ID_W-1:0]    sel;
   logic [ID_W-1:0]    take_id_q;
   logic [CNT_W-1:0]   count_q;
   logic               any_pend;
   logic               take;
   state_e             state_q;
   state_e             state_n;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of the order the always_ff blocks are evaluated in.
   // NOTE: the synchroniser array is reset like ordinary flops; a stale 1 left in
   // the chain after reset would otherwise fabricate an edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
         synced_d_q <= '0;
      end else begin
         sync_q[0] <= irq_src_i;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
         synced_d_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise     = sync_q[SYNC_STAGES-1] & ~synced_d_q;
   assign any_pend = |pending_q;

   // NOTE: sel gets its default before the loop so no path leaves it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      sel = '0;
      for (int i = NUM_SRC-1; i >= 0; i--) begin
         if (pending_q[i]) sel = ID_W'(i);
      end
   end

   always_comb begin
      state_n = state_q;
      take    = 1'b0;
      unique case (state_q)
         ST_RUN: begin
            if (any_pend && mstatus_mie_i && mie_meie_i && !pipe_stall_i) begin
               state_n = ST_TAKE;
               take    = 1'b1;
            end else if (wfi_i) begin
               state_n = ST_SLEEP;
            end
         end
         ST_SLEEP: begin
            // Wake ignores the global enable; it only decides take versus plain run.
            if (any_pend && mie_meie_i) begin
               if (mstatus_mie_i) begin
                  state_n = ST_TAKE;
                  take    = 1'b1;
               end else begin
                  state_n = ST_RUN;
               end
            end
         end
         ST_TAKE:    state_n = ST_HANDLER;
         ST_HANDLER: if (mret_i) state_n = ST_RUN;
         default:    state_n = ST_RUN;
      endcase
   end

   assign clr_mask = take ? (NUM_SRC'(1) << sel) : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_RUN;
         pending_q <= '0;
         take_id_q <= '0;
         count_q   <= '0;
      end else begin
         state_q   <= state_n;
         // A new edge on the bit being taken survives the clear.
         pending_q <= (pending_q & ~clr_mask) | rise;
         if (take) take_id_q <= sel;
         if (state_q == ST_TAKE && count_q != {CNT_W{1'b1}}) count_q <= count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         interrupt_o  <= 1'b0;
         sleep_o      <= 1'b0;
         in_handler_o <= 1'b0;
         irq_id_o     <= '0;
      end else begin
         interrupt_o  <= (state_q == ST_TAKE);
         sleep_o      <= (state_q == ST_SLEEP);
         in_handler_o <= (state_q == ST_HANDLER);
         irq_id_o     <= take_id_q;
      end
   end

   assign pending_o   = pending_q;
   assign irq_count_o = count_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: a cycle model built from the behavioural rules is
// compared every cycle, plus directed literal checks on latency, priority, WFI and reset.
module tb_irq_ctrl;

   localparam int NUM_SRC     = 4;
   localparam int SYNC_STAGES = 2;

   logic               clk = 1'b0;
   logic               rst;
   logic [NUM_SRC-1:0] irq_src_i;
   logic               mstatus_mie_i, mie_meie_i, wfi_i, mret_i, pipe_stall_i;

   logic               interrupt_o, sleep_o, in_handler_o;
   logic [1:0]         irq_id_o;
   logic [NUM_SRC-1:0] pending_o;
   logic [15:0]        irq_count_o;

   logic               s_interrupt, s_sleep, s_in_handler;
   logic [1:0]         s_irq_id;
   logic [NUM_SRC-1:0] s_pending;
   logic [1:0]         s_count;

   irq_ctrl #(.NUM_SRC(NUM_SRC), .SYNC_STAGES(SYNC_STAGES), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .irq_src_i(irq_src_i),
      .mstatus_mie_i(mstatus_mie_i), .mie_meie_i(mie_meie_i), .wfi_i(wfi_i),
      .mret_i(mret_i), .pipe_stall_i(pipe_stall_i),
      .interrupt_o(interrupt_o), .irq_id_o(irq_id_o), .sleep_o(sleep_o),
      .in_handler_o(in_handler_o), .pending_o(pending_o), .irq_count_o(irq_count_o)
   );

   // Narrow counter copy: shows saturation after a handful of takes.
   irq_ctrl #(.NUM_SRC(NUM_SRC), .SYNC_STAGES(SYNC_STAGES), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .irq_src_i(irq_src_i),
      .mstatus_mie_i(mstatus_mie_i), .mie_meie_i(mie_meie_i), .wfi_i(wfi_i),
      .mret_i(mret_i), .pipe_stall_i(pipe_stall_i),
      .interrupt_o(s_interrupt), .irq_id_o(s_irq_id), .sleep_o(s_sleep),
      .in_handler_o(s_in_handler), .pending_o(s_pending), .irq_count_o(s_count)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model: request history as a delay line, pending as a bit set,
   // controller mode as three exclusive flags, outputs visible one edge after the mode.
   logic [NUM_SRC-1:0] m_hist [SYNC_STAGES+1];
   logic [NUM_SRC-1:0] m_pend;
   bit                 m_asleep, m_taking, m_handling;
   int                 m_take_id, m_id;
   bit                 m_int, m_sleep, m_hand;
   longint             m_takes;

   initial begin
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) begin
            for (int k = 0; k <= SYNC_STAGES; k++) m_hist[k] = '0;
            m_pend = '0; m_asleep = 0; m_taking = 0; m_handling = 0;
            m_take_id = 0; m_id = 0; m_int = 0; m_sleep = 0; m_hand = 0; m_takes = 0;
         end else begin
            logic [NUM_SRC-1:0] edges;
            int  first;
            bit  go;
            edges   = m_hist[SYNC_STAGES-1] & ~m_hist[SYNC_STAGES];
            m_int   = m_taking;
            m_sleep = m_asleep;
            m_hand  = m_handling;
            m_id    = m_take_id;
            if (m_taking) m_takes++;
            first = 0;
            for (int i = NUM_SRC-1; i >= 0; i--) if (m_pend[i]) first = i;
            go = 0;
            if (m_taking) begin
               m_taking = 0; m_handling = 1;
            end else if (m_handling) begin
               if (mret_i) m_handling = 0;
            end else if (m_asleep) begin
               if (m_pend != 0 && mie_meie_i) begin
                  m_asleep = 0;
                  go = mstatus_mie_i;
               end
            end else if (m_pend != 0 && mstatus_mie_i && mie_meie_i && !pipe_stall_i) begin
               go = 1;
            end else if (wfi_i) begin
               m_asleep = 1;
            end
            if (go) begin
               m_taking = 1; m_take_id = first; m_pend[first] = 1'b0;
            end
            m_pend = m_pend | edges;
            for (int k = SYNC_STAGES; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = irq_src_i;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         check("interrupt_o", interrupt_o, m_int);
         check("irq_id_o", irq_id_o, m_id);
         check("sleep_o", sleep_o, m_sleep);
         check("in_handler_o", in_handler_o, m_hand);
         check("pending_o", pending_o, m_pend);
         check("irq_count_o", irq_count_o, (m_takes > 65535) ? 65535 : m_takes);
         check("sat.interrupt_o", s_interrupt, m_int);
         check("sat.irq_id_o", s_irq_id, m_id);
         check("sat.sleep_o", s_sleep, m_sleep);
         check("sat.in_handler_o", s_in_handler, m_hand);
         check("sat.pending_o", s_pending, m_pend);
         check("sat.irq_count_o", s_count, (m_takes > 3) ? 3 : m_takes);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_take(input int max, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (interrupt_o !== 1'b1 && n < max);
      check("take_seen", interrupt_o, 1);
   endtask

   task automatic mret_pulse();
      mret_i = 1'b1;
      tick(1);
      mret_i = 1'b0;
      tick(1);
   endtask

   int n;

   initial begin
      irq_src_i = '0; mstatus_mie_i = 0; mie_meie_i = 0;
      wfi_i = 0; mret_i = 0; pipe_stall_i = 0;
      rst = 1'b1;
      #1 rst = 1'b0;
      irq_src_i = 4'b1111;
      tick(3);
      check("rst.interrupt", interrupt_o, 0);
      check("rst.id", irq_id_o, 0);
      check("rst.sleep", sleep_o, 0);
      check("rst.handler", in_handler_o, 0);
      check("rst.pending", pending_o, 0);
      check("rst.count", irq_count_o, 0);
      rst = 1'b1;
      tick(2);
      check("pending_2clk", pending_o, 4'b0000);
      tick(1);
      check("pending_3clk", pending_o, 4'b1111);

      // Clean restart with no requests.
      rst = 1'b0; irq_src_i = '0;
      tick(2);
      rst = 1'b1; mstatus_mie_i = 1; mie_meie_i = 1;
      tick(2);

      // Single take from source 2.
      irq_src_i = 4'b0100;
      wait_take(10, n);
      check("single.latency", n, 5);
      check("single.id", irq_id_o, 2);
      check("single.count", irq_count_o, 1);
      tick(1);
      check("single.pulse_end", interrupt_o, 0);
      check("single.handler", in_handler_o, 1);
      irq_src_i = '0;
      mret_pulse();
      check("single.mret", in_handler_o, 0);

      // Priority and absorption.
      mstatus_mie_i = 0;
      irq_src_i = 4'b1010;
      tick(4);
      check("prio.pending", pending_o, 4'b1010);
      check("gate.no_take", interrupt_o, 0);
      irq_src_i = 4'b1000;
      tick(3);
      irq_src_i = 4'b1010;
      tick(4);
      check("prio.absorbed", pending_o, 4'b1010);
      irq_src_i = '0;
      mstatus_mie_i = 1;
      wait_take(6, n);
      check("prio.first_id", irq_id_o, 1);
      tick(1);
      mret_pulse();
      wait_take(8, n);
      check("prio.second_id", irq_id_o, 3);
      check("prio.count", irq_count_o, 3);
      wfi_i = 1;
      tick(1);
      wfi_i = 0;
      tick(2);
      check("handler.wfi_ignored", sleep_o, 0);
      mret_pulse();
      tick(6);
      check("prio.no_third", irq_count_o, 3);

      // Stall holds off the take.
      mstatus_mie_i = 0;
      irq_src_i = 4'b0001;
      tick(4);
      irq_src_i = '0;
      check("stall.pending", pending_o, 4'b0001);
      mstatus_mie_i = 1; pipe_stall_i = 1;
      tick(3);
      check("stall.no_take", interrupt_o, 0);
      pipe_stall_i = 0;
      wait_take(6, n);
      check("stall.latency", n, 2);
      check("stall.id", irq_id_o, 0);
      tick(1);
      mret_pulse();

      // WFI, wake without global enable.
      wfi_i = 1;
      tick(1);
      wfi_i = 0;
      tick(1);
      check("wfi.sleep", sleep_o, 1);
      mstatus_mie_i = 0;
      irq_src_i = 4'b1000;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (sleep_o !== 1'b0 && n < 10);
      check("wake.latency", n, 5);
      check("wake.no_pulse", interrupt_o, 0);
      check("wake.no_handler", in_handler_o, 0);
      irq_src_i = '0;
      tick(3);
      check("wake.still_pending", pending_o, 4'b1000);
      check("wake.still_no_pulse", interrupt_o, 0);
      mstatus_mie_i = 1;
      wait_take(6, n);
      check("wake.later_id", irq_id_o, 3);
      tick(1);
      mret_pulse();

      // WFI, wake straight into take.
      wfi_i = 1;
      tick(1);
      wfi_i = 0;
      tick(2);
      check("wfi2.sleep", sleep_o, 1);
      irq_src_i = 4'b0100;
      wait_take(8, n);
      check("wfi2.latency", n, 5);
      check("wfi2.sleep_clear", sleep_o, 0);
      check("wfi2.id", irq_id_o, 2);
      irq_src_i = '0;
      tick(1);
      mret_pulse();
      check("sat.count", s_count, 3);
      check("wide.count", irq_count_o, 6);

      // Asynchronous reset while in the handler with a new request pending.
      irq_src_i = 4'b0001;
      wait_take(8, n);
      irq_src_i = 4'b0010;
      tick(4);
      check("arst.pre_handler", in_handler_o, 1);
      check("arst.pre_pending", pending_o, 4'b0010);
      #2 rst = 1'b0;
      #1;
      check("arst.handler", in_handler_o, 0);
      check("arst.pending", pending_o, 0);
      check("arst.count", irq_count_o, 0);
      check("arst.id", irq_id_o, 0);
      irq_src_i = '0;
      tick(2);
      rst = 1'b1;
      tick(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Machine-mode external interrupt controller sitting directly upstream of the CSR unit.
- Synchronises asynchronous level requests from peripherals (DMA, EPU, WDT, spare) and latches them as pending on rising edges.
- Gates requests with the CSR enable bits, drives a one-cycle take pulse into the CSR `interrupt` input, and tracks WFI sleep and handler-active state.
- Returns to normal run on MRET.

Parameters:
- NUM_SRC, 4: number of interrupt sources; index 0 has highest priority.
- SYNC_STAGES, 2: flops in each source synchroniser chain; minimum 2.
- CNT_W, 16: width of the taken-interrupt counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low (0 = reset).
- irq_src_i  in  NUM_SRC  raw level requests from peripherals, asynchronous to clk.
- mstatus_mie_i  in  1  global enable, mstatus[3], from CSR unit.
- mie_meie_i  in  1  external enable, mie[11], from CSR unit.
- wfi_i  in  1  WFI instruction in EX this cycle.
- mret_i  in  1  MRET in EX this cycle; same signal as CSR_return.
- pipe_stall_i  in  1  hazard or memory stall this cycle.
- interrupt_o  out  1  one-cycle take pulse; connects to the CSR `interrupt` input.
- irq_id_o  out  $clog2(NUM_SRC)  index of the last taken source.
- sleep_o  out  1  core halted in WFI; pipeline freezes its PC.
- in_handler_o  out  1  handler active, between take and MRET.
- pending_o  out  NUM_SRC  pending bits, for debug and software visibility.
- irq_count_o  out  CNT_W  number of interrupts taken, saturating.

Behaviour:
- Reset (rst=0, async):
  - All synchroniser flops and edge-history flops = 0.
  - pending = 0; state = RUN; counter = 0.
  - All outputs = 0.
  - Reset mid-handler or mid-sleep returns to RUN immediately and discards all pending bits.
- Synchroniser:
  - Each source passes through a SYNC_STAGES flop chain.
  - edge[i] = synced[i] & ~synced_d[i], where synced_d is one further flop.
  - Levels held high generate exactly one edge.
- Pending:
  - pending[i] set at the clock after edge[i].
  - pending[i] cleared in the cycle state enters TAKE with id i.
  - Set and clear on the same bit in the same cycle: set wins, so the bit stays 1.
  - Edges on an already-pending bit are absorbed (no queueing).
- Selection: sel = lowest index i with pending[i]=1; any_pend = |pending.
- State machine; all outputs registered from state:
  - RUN:
    - If any_pend & mstatus_mie_i & mie_meie_i & !pipe_stall_i: go to TAKE and latch irq_id_o = sel.
    - Else if wfi_i: go to SLEEP.
    - Interrupt take has priority over wfi_i in the same cycle.
    - mret_i is ignored in RUN.
  - SLEEP:
    - sleep_o = 1.
    - Wake condition is any_pend & mie_meie_i; mstatus_mie_i is ignored for wake.
    - On wake: if mstatus_mie_i=1 go to TAKE (latch irq_id_o), else go to RUN with sleep_o = 0.
    - pipe_stall_i is ignored in SLEEP.
  - TAKE:
    - interrupt_o = 1 for exactly this one cycle.
    - Clear pending[irq_id_o].
    - irq_count_o increments by 1 and saturates at 2^CNT_W-1.
    - Next state = HANDLER unconditionally.
  - HANDLER:
    - in_handler_o = 1; no nesting, so new pending bits accumulate but are not taken.
    - mret_i for one cycle: go to RUN.
    - wfi_i is ignored.
- Latency (SYNC_STAGES=2, enables = 1, no stall): source sampled high at edge E1 -> interrupt_o high after edge E5, for one cycle. Total = SYNC_STAGES+3 edges.
- Output timing:
  - sleep_o deasserts on the same edge that sets TAKE or RUN.
  - in_handler_o asserts on the edge after TAKE.
- irq_id_o holds its value until the next take.

Test Plan:
- Reset check: rst=0 with irq_src_i=4'b1111 -> all outputs 0; release rst -> pending_o = 4'b1111 after 3 clocks.
- Single take: enables = 1, irq_src_i[2] rises -> interrupt_o pulses 1 cycle 5 edges later, irq_id_o = 2, in_handler_o = 1, irq_count_o = 1; mret_i pulse -> in_handler_o = 0 next cycle.
- Priority and absorption:
  - src[3] and src[1] rise together -> first take has id 1.
  - src[1] re-pulses while pending -> only one take for id 1.
  - After MRET -> second take has id 3.
- Gating and stall:
  - mstatus_mie_i = 0 with pending -> no take.
  - Set mstatus_mie_i = 1 with pipe_stall_i = 1 for 3 cycles -> take occurs the cycle after the stall drops.
- WFI:
  - wfi_i in RUN with nothing pending -> sleep_o = 1.
  - Source edge with mie_meie_i = 1, mstatus_mie_i = 0 -> sleep_o = 0, state RUN, no pulse.
  - Repeat with mstatus_mie_i = 1 -> wake straight into take.
- Saturation and async reset: force counter to 0xFFFF, take once -> count stays 0xFFFF; assert rst in HANDLER -> in_handler_o = 0 immediately, with no clock.
